// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
//   state_e     : fetch FSM states
//   pc_sel_e    : next-PC source select
//   DEFAULT_*   : default reset PC and exception vector
//   is_misaligned() : true when an address is not word aligned
package mips_pc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR
    } pc_sel_e;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0180;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Combinational next-PC selection.
// Ports:
//   pc          in  current instruction address
//   br_offset   in  sign-extended, shifted-left-2 branch offset
//   branch      in  conditional branch
//   br_cond     in  branch condition true
//   jump        in  J-type jump
//   jidx        in  26-bit jump index
//   jr          in  jump-register
//   jr_target   in  register value for jr
//   pc_plus4    out pc + 4 (wraps)
//   next_pc     out selected target, priority jr > jump > taken branch > pc+4
module pc_target_sel
    import mips_pc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] br_offset,
    input  logic        branch,
    input  logic        br_cond,
    input  logic        jump,
    input  logic [25:0] jidx,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] br_target;
    logic [31:0] j_target;
    pc_sel_e     sel;

    // 32-bit modulo arithmetic; carries out are discarded on purpose.
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + br_offset;
    assign j_target  = {pc_plus4[31:28], jidx, 2'b00};

    always_comb begin
        sel = SEL_SEQ;
        if (jr) begin
            sel = SEL_JR;
        end else if (jump) begin
            sel = SEL_J;
        end else if (branch && br_cond) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        unique case (sel)
            SEL_SEQ: next_pc = pc_plus4;
            SEL_BR:  next_pc = br_target;
            SEL_J:   next_pc = j_target;
            SEL_JR:  next_pc = jr_target;
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage.
// Fetches one instruction at a time over a req/ack memory handshake and hands
// it to decode via instr_valid/instr_ready. On each accept the PC advances to
// the priority-selected target from pc_target_sel.
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : a misaligned target redirects to EXC_VECTOR, misalign is sticky
//   undefined : target[1:0] forced to 2'b00, misalign tied 0
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   imem_req/addr        fetch request and address (addr == pc)
//   imem_ack/rdata       memory response
//   instr/instr_valid    registered instruction to decode
//   instr_ready          decode accepts instr
//   pc, pc_plus4         current address and pc + 4
//   br_offset, branch, br_cond, jump, jidx, jr, jr_target  next-PC controls
//   misalign             misaligned-target flag
module pc_fetch_unit
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [31:0] br_offset,
    input  logic        branch,
    input  logic        br_cond,
    input  logic        jump,
    input  logic [25:0] jidx,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        misalign
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;

    logic [31:0] next_pc;
    logic [31:0] target_pc;
    logic        trap;

    pc_target_sel u_target_sel (
        .pc        (pc_q),
        .br_offset (br_offset),
        .branch    (branch),
        .br_cond   (br_cond),
        .jump      (jump),
        .jidx      (jidx),
        .jr        (jr),
        .jr_target (jr_target),
        .pc_plus4  (pc_plus4),
        .next_pc   (next_pc)
    );

`ifdef PC_MISALIGN_TRAP_EN
    assign trap      = is_misaligned(next_pc);
    assign target_pc = trap ? EXC_VECTOR : next_pc;
`else
    logic unused_exc;
    assign unused_exc = ^EXC_VECTOR;
    assign trap       = 1'b0;
    assign target_pc  = next_pc & ~32'h0000_0003;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        imem_req   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Control inputs only matter in the accept cycle.
                if (instr_ready) begin
                    pc_d       = target_pc;
                    valid_d    = 1'b0;
                    misalign_d = misalign_q | trap;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign    = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q;
    assign misalign        = 1'b0;
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage; the direct consumer of the sign-extend/shift-left-2 path.
- Holds PC and fetches instructions over a req/ack memory handshake.
- Presents each fetched instruction to decode with a valid/ready handshake.
- At each instruction accept, selects the next PC: sequential PC+4, branch target (PC+4 plus shifted offset), jump target, or register target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0180, PC loaded on a misaligned target (optional feature only)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, always equals pc
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word
instr  output  32  registered instruction to decode
instr_valid  output  1  instr holds an unconsumed instruction
instr_ready  input  1  decode accepts instr this cycle
pc  output  32  address of current instruction
pc_plus4  output  32  pc+4, combinational
br_offset  input  32  sign-extended, shifted-left-2 branch offset
branch  input  1  current instruction is a conditional branch
br_cond  input  1  branch condition true (e.g. ALU zero)
jump  input  1  J-type jump
jidx  input  26  jump index field
jr  input  1  jump-register
jr_target  input  32  register value for jr
misalign  output  1  misaligned-target flag (optional feature; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, instr=0, instr_valid=0, misalign=0.
- States:
  - IDLE: one cycle after reset deasserts -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_valid<=1, -> HOLD. Without ack, stay in FETCH, holding req and addr stable.
  - HOLD: instr_valid=1, imem_req=0. On instr_ready ("accept" cycle): pc<=next_pc, instr_valid<=0, -> FETCH. Otherwise hold instr and pc unchanged.
- Throughput: minimum 2 cycles per instruction (ack in the first FETCH cycle, ready in the first HOLD cycle).
- next_pc is evaluated only in the accept cycle, from control inputs sampled that cycle. Priority: jr > jump > (branch & br_cond) > pc_plus4.
  - branch target = pc_plus4 + br_offset, 32-bit modulo; carry discarded, wraps 0xFFFF_FFFC+4 -> 0.
  - jump target = {pc_plus4[31:28], jidx, 2'b00}.
  - jr target = jr_target.
  - branch with br_cond=0 -> pc_plus4.
- Control inputs are ignored outside the accept cycle.
- pc_plus4 wraps: pc=0xFFFF_FFFC -> 0x0000_0000.
- imem_ack outside FETCH is ignored.
- Reset mid-operation (any state, including an outstanding request): immediate return to reset values; a late ack is ignored because the unit is no longer in FETCH.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: if the selected target has [1:0]!=2'b00, pc<=EXC_VECTOR and misalign<=1. misalign is sticky until reset.
- Undefined: target[1:0] is forced to 2'b00; misalign is tied 0.

Decomposition:
- Shared package mips_pc_pkg:
  - state enum {IDLE, FETCH, HOLD}.
  - next-PC select encoding {SEL_SEQ, SEL_BR, SEL_J, SEL_JR}.
  - default RESET_PC and EXC_VECTOR constants.
- One combinational sub-module, pc_target_sel: computes pc_plus4, the three targets, and the priority-selected next_pc. The FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset, then imem_ack=1 every FETCH cycle, instr_ready=1 always -> imem_addr sequence 0x0,0x4,0x8; new instr_valid every 2 cycles; instr matches imem_rdata.
- pc=0x100, branch=1, br_cond=1, br_offset=0xFFFF_FFF0 on accept -> next imem_addr 0x0F4. Same stimulus with br_cond=0 -> 0x104.
- pc=0x4000_0000, jump=1, jidx=0x0000010, branch=1, br_cond=1 same cycle -> next imem_addr 0x4000_0040 (jump beats branch). Add jr=1, jr_target=0x800 -> 0x800.
- imem_ack withheld 5 cycles, then instr_ready low 3 cycles in HOLD -> imem_req/imem_addr stable throughout the wait; instr, instr_valid and pc stable while ready is low; no double fetch.
- reset pulsed during FETCH with ack arriving the next cycle -> imem_req=0, pc=RESET_PC, instr_valid stays 0, fetch restarts from RESET_PC after IDLE.
- With PC_MISALIGN_TRAP_EN: jr_target=0x802 on accept -> pc=0x180, misalign=1. Without the macro: pc=0x800, misalign=0.
